// File: rtl/rx_iq_stream_ctrl_pkg.sv
// Shared constants, types and the byte-select helper for the RX IQ stream controller.
package rx_iq_stream_ctrl_pkg;

    localparam int DEPTH_DEF  = 8;      // default ring buffer entries
    localparam int SAMPLE_W   = 32;     // width of each I/Q word
    localparam int ENTRY_W    = 4 * SAMPLE_W;
    localparam logic [7:0] RX_IQ_CMD = 8'd4;  // bus command that carries this stream
    localparam int BYTES_RX1  = 8;      // frame bytes per sample, RX1 only
    localparam int BYTES_RX2  = 16;     // frame bytes per sample, RX1 + RX2
    localparam int OVF_CNT_W  = 16;     // saturating drop counter width

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Entry layout is {rx1_i, rx1_q, rx2_i, rx2_q}. Readout order is
    // RX1 Q, RX1 I, RX2 Q, RX2 I, each word MSB first.
    function automatic logic [7:0] iq_byte_sel(input logic [ENTRY_W-1:0] entry,
                                               input logic [3:0]         idx);
        logic [SAMPLE_W-1:0] w_word;
        case (idx[3:2])
            2'd0:    w_word = entry[3*SAMPLE_W-1 -: SAMPLE_W];  // rx1_q
            2'd1:    w_word = entry[4*SAMPLE_W-1 -: SAMPLE_W];  // rx1_i
            2'd2:    w_word = entry[SAMPLE_W-1:0];              // rx2_q
            default: w_word = entry[2*SAMPLE_W-1 -: SAMPLE_W];  // rx2_i
        endcase
        case (idx[1:0])
            2'd0:    return w_word[31:24];
            2'd1:    return w_word[23:16];
            2'd2:    return w_word[15:8];
            default: return w_word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/rx_iq_stream_ctrl_if.sv
// Signal bundle between the DDC / bus command side and the RX IQ stream controller.
// Handshake: iq_valid, frame_start, frame_end, byte_req and clear_stats are
// single-cycle strobes sampled on the rising clock edge; there is no ready
// path. byte_valid is a one-cycle pulse that qualifies byte_out in the cycle
// after the byte_req it answers; byte_out holds its value otherwise.
interface rx_iq_stream_ctrl_if #(
    parameter int DEPTH = rx_iq_stream_ctrl_pkg::DEPTH_DEF
);
    import rx_iq_stream_ctrl_pkg::*;

    localparam int FILL_W = $clog2(DEPTH) + 1;

    logic                 iq_valid;
    logic [SAMPLE_W-1:0]  rx1_i;
    logic [SAMPLE_W-1:0]  rx1_q;
    logic [SAMPLE_W-1:0]  rx2_i;
    logic [SAMPLE_W-1:0]  rx2_q;
    logic                 rx2_enable;
    logic                 frame_start;
    logic                 frame_end;
    logic                 byte_req;
    logic                 clear_stats;
    logic [7:0]           byte_out;
    logic                 byte_valid;
    logic                 underrun;
    logic                 overflow;
    logic [FILL_W-1:0]    fill_level;
    logic [OVF_CNT_W-1:0] overflow_cnt;
    state_t               dbg_state;

    modport master (
        output iq_valid, rx1_i, rx1_q, rx2_i, rx2_q, rx2_enable,
               frame_start, frame_end, byte_req, clear_stats,
        input  byte_out, byte_valid, underrun, overflow, fill_level,
               overflow_cnt, dbg_state
    );

    modport slave (
        input  iq_valid, rx1_i, rx1_q, rx2_i, rx2_q, rx2_enable,
               frame_start, frame_end, byte_req, clear_stats,
        output byte_out, byte_valid, underrun, overflow, fill_level,
               overflow_cnt, dbg_state
    );

endinterface

// File: rtl/rx_iq_stream_ctrl_iq_ring_buffer.sv
// Single-clock ring buffer of 128-bit IQ entries. When full, a write without a
// concurrent pop drops the oldest entry and counts the drop.
module rx_iq_stream_ctrl_iq_ring_buffer
    import rx_iq_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [ENTRY_W-1:0]       i_wr_data,
    input  logic                     i_rd_req,
    input  logic                     i_clear_stats,
    output logic [ENTRY_W-1:0]       o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill_level,
    output logic                     o_overflow,
    output logic [OVF_CNT_W-1:0]     o_overflow_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [FILL_W-1:0]    r_fill;
    logic                 r_overflow;
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_drop;

    assign w_empty = (r_fill == '0);
    assign w_full  = (r_fill == FILL_W'(DEPTH));
    // A pop on empty is refused here; the controller reports it as underrun.
    assign w_pop   = i_rd_req && !w_empty;
    // Write into a full buffer with no pop freeing a slot overwrites the oldest.
    assign w_drop  = i_wr_en && w_full && !w_pop;

    // Entry storage; contents need no reset since fill_level gates their use.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, fill level, overflow pulse and saturating drop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop || w_drop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_wr_en && !w_drop, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
            r_overflow <= w_drop;
            if (i_clear_stats) begin
                r_ovf_cnt <= '0;
            end else if (w_drop && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

    assign o_rd_data      = r_mem[r_rd_ptr];
    assign o_empty        = w_empty;
    assign o_fill_level   = r_fill;
    assign o_overflow     = r_overflow;
    assign o_overflow_cnt = r_ovf_cnt;

endmodule

// File: rtl/rx_iq_stream_ctrl.sv
// RX IQ stream controller: frames buffered DDC samples into the byte-serial
// stream read by the parallel bus engine during an RX IQ transfer.
module rx_iq_stream_ctrl
    import rx_iq_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    rx_iq_stream_ctrl_if.slave bus
);

    localparam int         FILL_W   = $clog2(DEPTH) + 1;
    localparam logic [3:0] LAST_RX1 = 4'(BYTES_RX1 - 1);
    localparam logic [3:0] LAST_RX2 = 4'(BYTES_RX2 - 1);

    state_t       r_state;
    logic [3:0]   r_idx;
    logic         r_rx2_lat;
    logic [ENTRY_W-1:0] r_hold;
    logic [7:0]   r_byte_out;
    logic         r_byte_valid;
    logic         r_underrun;

    logic [ENTRY_W-1:0]   w_entry;
    logic [ENTRY_W-1:0]   w_rd_data;
    logic                 w_rd_empty;
    logic [FILL_W-1:0]    w_fill_level;
    logic                 w_overflow;
    logic [OVF_CNT_W-1:0] w_ovf_cnt;
    logic                 w_accept;
    logic                 w_pop_req;
    logic [ENTRY_W-1:0]   w_src;
    logic [3:0]           w_last_idx;

    assign w_entry = {bus.rx1_i, bus.rx1_q, bus.rx2_i, bus.rx2_q};

    // byte_req loses to frame_start / frame_end in the same cycle.
    assign w_accept   = (r_state == ST_STREAM) && !bus.frame_start &&
                        !bus.frame_end && bus.byte_req;
    assign w_pop_req  = w_accept && (r_idx == 4'd0);
    // At index 0 the first byte comes straight from the popped entry; on an
    // empty buffer the previous sample is repeated from the hold register.
    assign w_src      = ((r_idx == 4'd0) && !w_rd_empty) ? w_rd_data : r_hold;
    assign w_last_idx = r_rx2_lat ? LAST_RX2 : LAST_RX1;

    rx_iq_stream_ctrl_iq_ring_buffer #(
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk          (clk_in),
        .i_rst          (reset),
        .i_wr_en        (bus.iq_valid),
        .i_wr_data      (w_entry),
        .i_rd_req       (w_pop_req),
        .i_clear_stats  (bus.clear_stats),
        .o_rd_data      (w_rd_data),
        .o_empty        (w_rd_empty),
        .o_fill_level   (w_fill_level),
        .o_overflow     (w_overflow),
        .o_overflow_cnt (w_ovf_cnt)
    );

    // Frame FSM with byte index, hold register and registered byte outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= 4'd0;
            r_rx2_lat    <= 1'b0;
            r_hold       <= '0;
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_underrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        r_state   <= ST_STREAM;
                        r_idx     <= 4'd0;
                        r_rx2_lat <= bus.rx2_enable;
                        r_hold    <= '0;
                    end
                end
                ST_STREAM: begin
                    if (bus.frame_start) begin
                        r_idx     <= 4'd0;
                        r_rx2_lat <= bus.rx2_enable;
                        r_hold    <= '0;
                    end else if (bus.frame_end) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 4'd0;
                    end else if (bus.byte_req) begin
                        r_byte_out   <= iq_byte_sel(w_src, r_idx);
                        r_byte_valid <= 1'b1;
                        if (r_idx == 4'd0) begin
                            r_hold     <= w_src;
                            r_underrun <= w_rd_empty;
                        end
                        r_idx <= (r_idx == w_last_idx) ? 4'd0 : r_idx + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_out     = r_byte_out;
    assign bus.byte_valid   = r_byte_valid;
    assign bus.underrun     = r_underrun;
    assign bus.overflow     = w_overflow;
    assign bus.fill_level   = w_fill_level;
    assign bus.overflow_cnt = w_ovf_cnt;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_rx_iq_stream_ctrl.sv
// Directed bench for rx_iq_stream_ctrl: a vector table for the basic frame
// formats, then hand-written sequences for overflow, underrun, restart,
// mid-frame reset and statistics clearing.
module tb_rx_iq_stream_ctrl;
    import rx_iq_stream_ctrl_pkg::*;

    localparam int DEPTH = 8;

    // Clock and reset
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    rx_iq_stream_ctrl_if #(.DEPTH(DEPTH)) bus ();

    rx_iq_stream_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        string        name;
        logic         fs;
        logic         fe;
        logic         br;
        logic         r2;
        logic         iqv;
        logic         clr;
        logic [127:0] ent;
        logic         ebv;
        logic [7:0]   eb;
        logic         eur;
        logic         eov;
        int           efill;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] bytes_a [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    logic [7:0] bytes_s [8]  = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1C, 8'h1D};

    // Scoreboard compare
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Entry packing matches the sample fields driven onto the bus.
    function automatic logic [127:0] smp(input logic [31:0] r1q, input logic [31:0] r1i,
                                         input logic [31:0] r2q, input logic [31:0] r2i);
        return {r1i, r1q, r2i, r2q};
    endfunction

    // Numbered sample k: every RX1 Q byte = k, every RX1 I byte = k | 0x80.
    function automatic logic [127:0] kent(input int k);
        logic [7:0] b;
        b = k[7:0];
        return smp({4{b}}, {4{b | 8'h80}}, 32'h0, 32'h0);
    endfunction

    function automatic logic [7:0] kbyte(input int k, input int i);
        logic [7:0] b;
        b = k[7:0];
        return (i < 4) ? b : (b | 8'h80);
    endfunction

    function automatic vec_t mk(input string nm, input logic fs, input logic fe,
                                input logic br, input logic r2, input logic iqv,
                                input logic clr, input logic [127:0] ent,
                                input logic ebv, input logic [7:0] eb,
                                input logic eur, input logic eov, input int efill);
        vec_t v;
        v.name = nm; v.fs = fs; v.fe = fe; v.br = br; v.r2 = r2; v.iqv = iqv;
        v.clr = clr; v.ent = ent; v.ebv = ebv; v.eb = eb; v.eur = eur;
        v.eov = eov; v.efill = efill;
        return v;
    endfunction

    // Driver: present one cycle of inputs, check outputs #1 after the edge.
    task automatic apply(input vec_t v);
        bus.frame_start = v.fs;
        bus.frame_end   = v.fe;
        bus.byte_req    = v.br;
        bus.rx2_enable  = v.r2;
        bus.iq_valid    = v.iqv;
        bus.clear_stats = v.clr;
        bus.rx1_i       = v.ent[127:96];
        bus.rx1_q       = v.ent[95:64];
        bus.rx2_i       = v.ent[63:32];
        bus.rx2_q       = v.ent[31:0];
        @(posedge clk_in);
        #1;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.byte_req    = 1'b0;
        bus.iq_valid    = 1'b0;
        bus.clear_stats = 1'b0;
        check({v.name, " byte_valid"}, 32'(bus.byte_valid), 32'(v.ebv));
        if (v.ebv) check({v.name, " byte_out"}, 32'(bus.byte_out), 32'(v.eb));
        check({v.name, " underrun"}, 32'(bus.underrun), 32'(v.eur));
        check({v.name, " overflow"}, 32'(bus.overflow), 32'(v.eov));
        check({v.name, " fill_level"}, 32'(bus.fill_level), 32'(v.efill));
    endtask

    initial begin
        logic [127:0] smp_a;
        logic [127:0] smp_b;
        logic [127:0] smp_s;
        logic [127:0] smp_t;

        bus.iq_valid = 0; bus.frame_start = 0; bus.frame_end = 0; bus.byte_req = 0;
        bus.rx2_enable = 0; bus.clear_stats = 0;
        bus.rx1_i = '0; bus.rx1_q = '0; bus.rx2_i = '0; bus.rx2_q = '0;

        smp_a = smp(32'h11223344, 32'h55667788, 32'hA1A2A3A4, 32'hB1B2B3B4);
        smp_b = smp(32'hC1C2C3C4, 32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4);
        smp_s = smp(32'h0A0B0C0D, 32'h1A1B1C1D, 32'h0, 32'h0);
        smp_t = smp(32'h2A2B2C2D, 32'h3A3B3C3D, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        check("rst byte_out", 32'(bus.byte_out), 32'h0);
        check("rst byte_valid", 32'(bus.byte_valid), 32'h0);
        check("rst underrun", 32'(bus.underrun), 32'h0);
        check("rst overflow", 32'(bus.overflow), 32'h0);
        check("rst fill_level", 32'(bus.fill_level), 32'h0);
        check("rst overflow_cnt", 32'(bus.overflow_cnt), 32'h0);
        check("rst state", 32'(bus.dbg_state), 32'(ST_IDLE));
        reset = 1'b0;

        // Vector table: RX1-only frame, then RX1+RX2 frame with a restart
        vecs.push_back(mk("idle_req", 0,0,1,0,0,0, '0,    0,8'h00,0,0,0));
        vecs.push_back(mk("a_start",  1,0,0,0,0,0, '0,    0,8'h00,0,0,0));
        vecs.push_back(mk("a_write",  0,0,0,0,1,0, smp_a, 0,8'h00,0,0,1));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk($sformatf("a_byte%0d", i), 0,0,1,0,0,0, '0,
                              1, bytes_a[i], 0,0,0));
        vecs.push_back(mk("b_start",  1,0,0,1,0,0, '0,    0,8'h00,0,0,0));
        vecs.push_back(mk("b_write_a",0,0,0,1,1,0, smp_a, 0,8'h00,0,0,1));
        vecs.push_back(mk("b_write_b",0,0,0,1,1,0, smp_b, 0,8'h00,0,0,2));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk($sformatf("b_byte%0d", i), 0,0,1,1,0,0, '0,
                              1, bytes_a[i], 0,0,1));
        vecs.push_back(mk("b_byte16", 0,0,1,1,0,0, '0,    1,8'hC1,0,0,0));
        vecs.push_back(mk("b_end",    0,1,0,0,0,0, '0,    0,8'h00,0,0,0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Underrun repeats the previous sample; write+pop on empty stores the write
        apply(mk("u_write_s", 0,0,0,0,1,0, smp_s, 0,8'h00,0,0,1));
        apply(mk("u_start",   1,0,0,0,0,0, '0,    0,8'h00,0,0,1));
        for (int i = 0; i < 8; i++)
            apply(mk($sformatf("u_s%0d", i), 0,0,1,0,0,0, '0, 1, bytes_s[i], 0,0,0));
        apply(mk("u_empty",   0,0,1,0,0,0, '0,    1,8'h0A,1,0,0));
        for (int i = 1; i < 8; i++)
            apply(mk($sformatf("u_rep%0d", i), 0,0,1,0,0,0, '0, 1, bytes_s[i], 0,0,0));
        apply(mk("u_wr_pop",  0,0,1,0,1,0, smp_t, 1,8'h0A,1,0,1));
        for (int i = 1; i < 8; i++)
            apply(mk($sformatf("u_rep2_%0d", i), 0,0,1,0,0,0, '0, 1, bytes_s[i], 0,0,1));
        apply(mk("u_pop_t",   0,0,1,0,0,0, '0,    1,8'h2A,0,0,0));
        apply(mk("u_end",     0,1,0,0,0,0, '0,    0,8'h00,0,0,0));

        // DEPTH+3 writes with no reads: three oldest samples dropped
        for (int k = 1; k <= DEPTH + 3; k++)
            apply(mk($sformatf("o_write%0d", k), 0,0,0,0,1,0, kent(k),
                     0,8'h00,0,(k > DEPTH), (k > DEPTH) ? DEPTH : k));
        check("o_overflow_cnt", 32'(bus.overflow_cnt), 32'd3);
        apply(mk("o_start",   1,0,0,0,0,0, '0,    0,8'h00,0,0,8));
        check("o_state", 32'(bus.dbg_state), 32'(ST_STREAM));
        apply(mk("o_first",   0,0,1,0,0,0, '0,    1,8'h04,0,0,7));
        for (int i = 1; i < 5; i++)
            apply(mk($sformatf("o_s4_%0d", i), 0,0,1,0,0,0, '0, 1, kbyte(4, i), 0,0,7));

        // Restart at byte index 5 pops a fresh sample
        apply(mk("r_restart", 1,0,0,0,0,0, '0,    0,8'h00,0,0,7));
        apply(mk("r_first",   0,0,1,0,0,0, '0,    1,8'h05,0,0,6));
        for (int i = 1; i < 8; i++)
            apply(mk($sformatf("r_s5_%0d", i), 0,0,1,0,0,0, '0, 1, kbyte(5, i), 0,0,6));
        for (int i = 0; i < 8; i++)
            apply(mk($sformatf("r_s6_%0d", i), 0,0,1,0,0,0, '0, 1, kbyte(6, i), 0,0,5));
        for (int i = 0; i < 3; i++)
            apply(mk($sformatf("r_s7_%0d", i), 0,0,1,0,0,0, '0, 1, kbyte(7, i), 0,0,4));
        check("r_overflow_cnt", 32'(bus.overflow_cnt), 32'd3);

        // Asynchronous reset mid-frame at byte index 3, fill_level 4
        reset = 1'b1;
        #2;
        check("x_fill_level", 32'(bus.fill_level), 32'd0);
        check("x_byte_valid", 32'(bus.byte_valid), 32'd0);
        check("x_byte_out", 32'(bus.byte_out), 32'h0);
        check("x_overflow_cnt", 32'(bus.overflow_cnt), 32'd0);
        check("x_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        apply(mk("x_idle_req",0,0,1,0,0,0, '0,    0,8'h00,0,0,0));
        apply(mk("x_start",   1,0,0,0,0,0, '0,    0,8'h00,0,0,0));
        apply(mk("x_underrun",0,0,1,0,0,0, '0,    1,8'h00,1,0,0));

        // clear_stats coincident with overflow, and write+pop when full
        apply(mk("c_start",   1,0,0,0,0,0, '0,    0,8'h00,0,0,0));
        for (int k = 21; k < 21 + DEPTH; k++)
            apply(mk($sformatf("c_write%0d", k), 0,0,0,0,1,0, kent(k),
                     0,8'h00,0,0, k - 20));
        apply(mk("c_ovf_clr", 0,0,0,0,1,1, kent(29), 0,8'h00,0,1,DEPTH));
        check("c_cnt_after_clr", 32'(bus.overflow_cnt), 32'd0);
        apply(mk("c_ovf",     0,0,0,0,1,0, kent(30), 0,8'h00,0,1,DEPTH));
        check("c_cnt_one", 32'(bus.overflow_cnt), 32'd1);
        apply(mk("c_wr_pop",  0,0,1,0,1,0, kent(31), 1,8'h17,0,0,DEPTH));
        check("c_cnt_hold", 32'(bus.overflow_cnt), 32'd1);
        apply(mk("c_clear",   0,0,0,0,0,1, '0,    0,8'h00,0,0,DEPTH));
        check("c_cnt_cleared", 32'(bus.overflow_cnt), 32'd0);
        apply(mk("c_end",     0,1,0,0,0,0, '0,    0,8'h00,0,0,DEPTH));

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
